ram_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one port of the 16x8 dual-port RAM between NUM_REQ requesters.

---
 rtl/ram_rr_arbiter_pkg.sv | 22 ++
 rtl/ram_rr_arbiter_rr_picker.sv | 31 +++
 rtl/ram_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_rr_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rr_arbiter_pkg.sv
// Shared definitions for the round-robin RAM port arbiter: size defaults,
// lock FSM state encoding and small index helpers.
package ram_rr_arbiter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/ram_rr_arbiter_rr_picker.sv
// Combinational rotate-priority picker: the first set request at or after ptr
// (wrapping) wins, reported both one-hot and as an index.
module ram_rr_arbiter_rr_picker #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr) + off) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters.
// Optional ownership lock enabled by defining RAM_ARB_LOCK_EN.
//
// Handshake: a requester raises req[i] with stable fields and holds them until
// accepted; accept = req[i] & gnt[i] at a rising edge. Read responses are not
// back-pressured: rsp_valid is asserted for one cycle and must be taken.
module ram_rr_arbiter
  import ram_rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int DEPTH   = DEF_DEPTH,
  localparam int ADDR    = $clog2(DEPTH),
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ*ADDR-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
  output lock_state_e              dbg_state,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     ram_en,
  output logic                     ram_rd_en,
  output logic [ADDR-1:0]          ram_addr,
  output logic [WIDTH-1:0]         ram_din,
  input  logic [WIDTH-1:0]         ram_dout,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_data
);

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDW-1:0]     win_idx;
  logic               pick_any;
  logic               accept;
  logic               win_we;
  int                 sel;

`ifdef RAM_ARB_LOCK_EN
  lock_state_e        state_q, state_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0] owner_mask;

  // While locked only the owner is visible to the picker, even when idle.
  always_comb begin
    owner_mask = NUM_REQ'(1) << owner_q;
    pick_req   = (state_q == ST_LOCKED) ? (req & owner_mask) : req;
  end
`else
  assign pick_req = req;
`endif

  ram_rr_arbiter_rr_picker #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_picker (
    .req (pick_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (win_idx),
    .any (pick_any)
  );

  // Grants are masked by reset directly so they drop without waiting for an edge.
  assign gnt    = rst ? '0 : pick_gnt;
  assign accept = pick_any & ~rst;
  assign win_we = req_we[win_idx];

  always_comb begin
    sel       = int'(win_idx);
    ram_en    = accept;
    ram_rd_en = accept & ~win_we;
    ram_addr  = '0;
    ram_din   = '0;
    if (accept) begin
      ram_addr = req_addr[sel*ADDR +: ADDR];
      ram_din  = req_wdata[sel*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = accept & ~win_we;
    rsp_id_d    = rsp_id_q;
    if (accept) begin
      ptr_d = IDW'(wrap_inc(int'(win_idx), NUM_REQ));
      if (!win_we) begin
        rsp_id_d = win_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

`ifdef RAM_ARB_LOCK_EN
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (req_lock[win_idx]) begin
            state_d = ST_LOCKED;
            owner_d = win_idx;
          end
        end
        ST_LOCKED: begin
          if (!req_lock[win_idx]) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign dbg_state = state_q;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = ram_dout;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter with a behavioural RAM on the shared
// port; also covers the lock feature when RAM_ARB_LOCK_EN is defined.
module tb_ram_rr_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int D   = 16;
  localparam int A   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_we;
  logic [N*A-1:0] req_addr;
  logic [N*W-1:0] req_wdata;
  logic [N-1:0]   gnt;
  logic           ram_en, ram_rd_en;
  logic [A-1:0]   ram_addr;
  logic [W-1:0]   ram_din, ram_dout;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
`ifdef RAM_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
  ram_rr_arbiter_pkg::lock_state_e dbg_state;
`endif

  always #5 clk = ~clk;

  ram_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef RAM_ARB_LOCK_EN
    .req_lock  (req_lock),
    .dbg_state (dbg_state),
`endif
    .gnt       (gnt),
    .ram_en    (ram_en),
    .ram_rd_en (ram_rd_en),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  // Port-1 RAM with registered read.
  logic [W-1:0] ram_mem [D];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_rd_en) ram_dout <= ram_mem[ram_addr];
      else           ram_mem[ram_addr] <= ram_din;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction word: {lock, we, addr[3:0], data[7:0]}.
  logic [13:0]        txq [N][$];
  logic [IDW+W-1:0]   exp_q [$];
  logic [W-1:0]       shadow [D];
  int                 glog [$];
  int                 m_ptr;
  bit                 m_locked;
  int                 m_owner;

  function automatic logic [13:0] tx(input bit lk, input bit we, input logic [3:0] a, input logic [7:0] d);
    return {lk, we, a, d};
  endfunction

  task automatic drive();
    logic [13:0] t;
    for (int i = 0; i < N; i++) begin
      t = '0;
      if (txq[i].size() > 0) t = txq[i][0];
      req[i]            = (txq[i].size() > 0);
      req_we[i]         = t[12];
      req_addr[i*A +: A] = t[11:8];
      req_wdata[i*W +: W] = t[7:0];
`ifdef RAM_ARB_LOCK_EN
      req_lock[i]       = t[13];
`endif
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (txq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    int               w;
    int               k;
    logic [13:0]      t;
    logic [N-1:0]     eg;
    logic [IDW+W-1:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("rsp_valid", rsp_valid, 1);
      check_eq("rsp_id", rsp_id, e[W +: IDW]);
      check_eq("rsp_data", rsp_data, e[W-1:0]);
    end else begin
      check_eq("rsp_idle", rsp_valid, 0);
    end
    w = -1;
    for (int off = 0; off < N; off++) begin
      k = (m_ptr + off) % N;
      if (w < 0 && req[k] && (!m_locked || k == m_owner)) w = k;
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    check_eq("gnt", gnt, eg);
    check_eq("ram_en", ram_en, (w >= 0));
    if (w >= 0) begin
      t = txq[w][0];
      glog.push_back(w);
      check_eq("ram_addr", ram_addr, t[11:8]);
      check_eq("ram_rd_en", ram_rd_en, !t[12]);
      if (t[12]) begin
        check_eq("ram_din", ram_din, t[7:0]);
        shadow[t[11:8]] = t[7:0];
      end else begin
        exp_q.push_back({w[IDW-1:0], shadow[t[11:8]]});
      end
      m_ptr = (w + 1) % N;
`ifdef RAM_ARB_LOCK_EN
      if (!m_locked && t[13]) begin
        m_locked = 1'b1;
        m_owner  = w;
      end else if (m_locked && !t[13]) begin
        m_locked = 1'b0;
      end
`endif
    end else begin
      check_eq("ram_addr_idle", ram_addr, 0);
      check_eq("ram_din_idle", ram_din, 0);
    end
    @(posedge clk);
    #1;
    if (w >= 0) void'(txq[w].pop_front());
    drive();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((pending() || exp_q.size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    if (pending() || exp_q.size() > 0) check_eq("drain_timeout", 1, 0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    exp_q.delete();
    m_ptr    = 0;
    m_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int fair_exp [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    for (int i = 0; i < D; i++) begin
      ram_mem[i] = W'(i * 17 + 3);
      shadow[i]  = W'(i * 17 + 3);
    end
    m_ptr    = 0;
    m_locked = 1'b0;
    m_owner  = 0;
    rst      = 1'b1;

    // Reset with every requester asking.
    for (int i = 0; i < N; i++) txq[i].push_back(tx(0, 0, 4'(i + 8), 8'h00));
    txq[0].push_back(tx(0, 0, 4'h1, 8'h00));
    txq[1].push_back(tx(0, 0, 4'h2, 8'h00));
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_gnt", gnt, 0);
    check_eq("reset_ram_en", ram_en, 0);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rsp_id", rsp_id, 0);
    rst = 1'b0;

    // Fairness: grant order 0,1,2,3,0,1.
    glog.delete();
    drain(50);
    for (int i = 0; i < 6; i++) check_eq($sformatf("fair_order%0d", i), glog[i], fair_exp[i]);

    // Write from requester 2, then read back from requester 1.
    txq[2].push_back(tx(0, 1, 4'h3, 8'hA5));
    drive();
    step();
    txq[1].push_back(tx(0, 0, 4'h3, 8'h00));
    drive();
    drain(20);

    // Skip idle requesters with ptr at 1.
    txq[0].push_back(tx(0, 0, 4'h5, 8'h00));
    drive();
    drain(20);
    glog.delete();
    txq[0].push_back(tx(0, 0, 4'h6, 8'h00));
    txq[3].push_back(tx(0, 0, 4'h7, 8'h00));
    drive();
    step();
    step();
    check_eq("skip_first", glog[0], 3);
    check_eq("skip_second", glog[1], 0);
    drain(20);

    // Random mixed traffic.
    for (int n = 0; n < 48; n++) begin
      txq[$urandom_range(0, N-1)].push_back(
        tx(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, D-1)), 8'($urandom_range(0, 255))));
    end
    drive();
    drain(200);

    // Asynchronous reset in the middle of a read burst.
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 3; r++) txq[i].push_back(tx(0, 0, 4'($urandom_range(0, D-1)), 8'h00));
    drive();
    step();
    step();
    step();
    async_reset();
    glog.delete();
    drain(50);
    check_eq("post_reset_first", glog[0], 0);

`ifdef RAM_ARB_LOCK_EN
    // Requester 1 holds the port for three writes while 0 and 2 wait.
    txq[0].push_back(tx(0, 0, 4'h0, 8'h00));
    drive();
    drain(20);
    glog.delete();
    txq[1].push_back(tx(1, 1, 4'h9, 8'h11));
    txq[1].push_back(tx(1, 1, 4'hA, 8'h22));
    txq[1].push_back(tx(0, 1, 4'hB, 8'h33));
    txq[0].push_back(tx(0, 0, 4'h9, 8'h00));
    txq[2].push_back(tx(0, 0, 4'hA, 8'h00));
    drive();
    drain(30);
    check_eq("lock_g0", glog[0], 1);
    check_eq("lock_g1", glog[1], 1);
    check_eq("lock_g2", glog[2], 1);
    check_eq("lock_g3", glog[3], 2);
    check_eq("lock_state_idle", dbg_state, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
